// File: rtl/paced_gen_pkg.sv
// Shared state type, constants and LFSR step function for the paced value generator.
package paced_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_GAP,
        WAIT_GAP,
        EMIT,
        TAIL,
        DONE
    } gen_state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          VALUE_MOD = 100;

    // 16-bit Galois LFSR, shift right, feedback on the bit shifted out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/paced_gen_lfsr.sv
// LFSR state register for the paced value generator; a zero seed is replaced by 1.
module paced_gen_lfsr
    import paced_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_step,
    output logic [15:0] o_state
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= SEED_EFF;
        end else if (i_step) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_state = r_lfsr;

endmodule

// File: rtl/paced_value_gen.sv
// Paced pseudo-random value source over valid/ready, with random idle gaps and a done pulse.
// Optional ignored-start counter (start_drops) when PACED_VALUE_GEN_DROP_CNT_EN is defined.
module paced_value_gen
    import paced_gen_pkg::*;
#(
    parameter int          DATA_W      = 6,
    parameter int          NUM_UPDATES = 30,
    parameter int          MIN_GAP     = 5,
    parameter int          MAX_GAP     = 10,
    parameter int          TAIL_CYCLES = 100,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
`ifdef PACED_VALUE_GEN_DROP_CNT_EN
    output logic [7:0]        start_drops,
`endif
    output logic [7:0]        issued
);

    localparam logic [15:0] GAP_MIN   = 16'(MIN_GAP);
    localparam logic [15:0] GAP_SPAN  = 16'(MAX_GAP - MIN_GAP + 1);
    localparam logic [15:0] TAIL_LAST = (TAIL_CYCLES > 0) ? 16'(TAIL_CYCLES - 1) : 16'd0;
    localparam logic [7:0]  NUM_LAST  = 8'(NUM_UPDATES);

    gen_state_t        r_state;
    gen_state_t        w_state_nxt;
    logic [15:0]       r_gap_cnt;
    logic [15:0]       r_tail_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic [7:0]        r_issued;
    logic [15:0]       w_lfsr;
    logic              w_lfsr_step;
    logic              w_hs;
    logic              w_last;
    logic [15:0]       w_gap;
    logic [DATA_W-1:0] w_value;

    paced_gen_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_step  (w_lfsr_step),
        .o_state (w_lfsr)
    );

    assign w_gap   = GAP_MIN + ({8'h00, w_lfsr[7:0]} % GAP_SPAN);
    // Signed remainder truncates toward zero, giving -99..99 before narrowing.
    assign w_value = DATA_W'($signed(w_lfsr[15:8]) % VALUE_MOD);
    assign w_last  = ((r_issued + 8'd1) == NUM_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_step = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            IDLE:     if (start) w_state_nxt = LOAD_GAP;
            LOAD_GAP: begin
                w_state_nxt = WAIT_GAP;
                w_lfsr_step = 1'b1;
            end
            WAIT_GAP: if (r_gap_cnt == '0) w_state_nxt = EMIT;
            EMIT: begin
                if (out_ready) begin
                    w_hs        = 1'b1;
                    w_lfsr_step = 1'b1;
                    w_state_nxt = w_last ? TAIL : LOAD_GAP;
                end
            end
            TAIL:     if (r_tail_cnt == '0) w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
        out_valid = (r_state == EMIT);
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gap_cnt  <= '0;
            r_tail_cnt <= '0;
            r_out_data <= '0;
            r_issued   <= '0;
        end else begin
            case (r_state)
                IDLE:     if (start) r_issued <= '0;
                LOAD_GAP: r_gap_cnt <= w_gap - 16'd1;
                WAIT_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_out_data <= w_value;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                EMIT: begin
                    if (w_hs) begin
                        r_issued   <= r_issued + 8'd1;
                        r_tail_cnt <= TAIL_LAST;
                    end
                end
                TAIL:     if (r_tail_cnt != '0) r_tail_cnt <= r_tail_cnt - 16'd1;
                default:  ;
            endcase
        end
    end

`ifdef PACED_VALUE_GEN_DROP_CNT_EN
    logic [7:0] r_drops;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drops <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_drops <= '0;
        end else if (start && busy && (r_drops != 8'hFF)) begin
            r_drops <= r_drops + 8'd1;
        end
    end

    assign start_drops = r_drops;
`endif

    assign out_data = r_out_data;
    assign issued   = r_issued;

endmodule
